// File: rtl/pattern_player_pkg.sv
// Shared definitions for the pattern player: FSM states, digit geometry
// and the seed-to-digit extraction helper.
package pattern_player_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int DIGIT_W    = 3;
   localparam int SEED_W     = 20;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } pp_state_e;

   // Digit k occupies seed bits [3k+2:3k]; the top two seed bits are never used.
   function automatic logic [DIGIT_W-1:0] get_digit(input logic [SEED_W-1:0] s,
                                                    input logic [2:0] k);
      return s[int'(k)*DIGIT_W +: DIGIT_W];
   endfunction

endpackage

// File: rtl/pattern_tick_timer.sv
// Loadable down-counter. Loading value L makes expired_o rise on the L-th
// cycle after the load edge, so a state entered on the load edge lasts
// exactly L cycles when it leaves on expiry. Once at zero it holds there.
module pattern_tick_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             expired_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: reload on request, otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i - CNT_W'(1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Count register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/pattern_player.sv
// Pattern player: on start, latches a seed and difficulty level and plays six
// 3-bit digits as positions, each shown for ON_TICKS>>level cycles followed by
// a GAP_TICKS blank, then pulses done.
// Optional feature macro: PATTERN_DUP_AVOID_EN -- when defined, a digit equal
// to the previously shown position is bumped by one (mod 8).
module pattern_player
   import pattern_player_pkg::*;
#(
   parameter int ON_TICKS  = 8,
   parameter int GAP_TICKS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [SEED_W-1:0] seed,
   input  logic [1:0]        level,
   input  logic              abort,
   output logic [2:0]        pos,
   output logic              pos_valid,
   output logic [2:0]        step_idx,
   output logic              busy,
   output logic              done
);

   localparam int MAX_TICKS = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
   localparam int CNT_W     = $clog2(MAX_TICKS + 1);

   pp_state_e          state_q, state_d;
   logic [2:0]         step_q, step_d;
   logic [SEED_W-1:0]  seed_q, seed_d;
   logic [1:0]         level_q, level_d;
   logic [DIGIT_W-1:0] pos_q, pos_d;

   logic               tmr_load;
   logic [CNT_W-1:0]   tmr_load_val;
   logic               tmr_expired;

   logic [DIGIT_W-1:0] raw_next;
   logic [DIGIT_W-1:0] shown_next;
   logic               unused_seed_bits;

   function automatic logic [CNT_W-1:0] show_len(input logic [1:0] lv);
      return CNT_W'(ON_TICKS >> lv);
   endfunction

   assign raw_next = get_digit(seed_q, step_q + 3'd1);

`ifdef PATTERN_DUP_AVOID_EN
   assign shown_next = (raw_next == pos_q) ? raw_next + DIGIT_W'(1) : raw_next;
`else
   assign shown_next = raw_next;
`endif

   assign unused_seed_bits = ^seed_q[SEED_W-1:NUM_DIGITS*DIGIT_W];

   pattern_tick_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .expired_o  (tmr_expired)
   );

   // Next-state logic: sequencing of SHOW/GAP per digit, abort and start handling.
   always_comb begin
      state_d      = state_q;
      step_d       = step_q;
      seed_d       = seed_q;
      level_d      = level_q;
      pos_d        = pos_q;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      case (state_q)
         ST_IDLE: begin
            // abort outranks a simultaneous start
            if (start && !abort) begin
               state_d      = ST_SHOW;
               seed_d       = seed;
               level_d      = level;
               step_d       = 3'd0;
               pos_d        = get_digit(seed, 3'd0);
               tmr_load     = 1'b1;
               tmr_load_val = show_len(level);
            end
         end
         ST_SHOW: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (tmr_expired) begin
               state_d      = ST_GAP;
               tmr_load     = 1'b1;
               tmr_load_val = CNT_W'(GAP_TICKS);
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (tmr_expired) begin
               if (step_q < 3'(NUM_DIGITS - 1)) begin
                  state_d      = ST_SHOW;
                  step_d       = step_q + 3'd1;
                  pos_d        = shown_next;
                  tmr_load     = 1'b1;
                  tmr_load_val = show_len(level_q);
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and latched-pattern registers, all cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         seed_q  <= '0;
         level_q <= '0;
         pos_q   <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         seed_q  <= seed_d;
         level_q <= level_d;
         pos_q   <= pos_d;
      end
   end

   assign pos       = pos_q;
   assign step_idx  = step_q;
   assign pos_valid = (state_q == ST_SHOW);
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_pattern_player.sv
// Directed bench for pattern_player with default parameters (ON_TICKS=8,
// GAP_TICKS=2). Cycle c counts clock periods after the accepting edge, so
// with level 0 the done pulse sits in period 61.
module tb_pattern_player;

   typedef logic [2:0] dig_t [6];

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [19:0] seed;
   logic [1:0]  level;
   logic        abort;
   logic [2:0]  pos;
   logic        pos_valid;
   logic [2:0]  step_idx;
   logic        busy;
   logic        done;

   int n_chk = 0;
   int n_err = 0;

   pattern_player #(
      .ON_TICKS  (8),
      .GAP_TICKS (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .seed      (seed),
      .level     (level),
      .abort     (abort),
      .pos       (pos),
      .pos_valid (pos_valid),
      .step_idx  (step_idx),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] outv();
      return {23'd0, pos_valid, pos, step_idx, busy, done};
   endfunction

   // Plays one pattern and checks every cycle. Optional injections:
   // abort_c / rst_c = cycle to abort or reset in (0 = none), spam = extra
   // starts during playback, done_start = start asserted in the DONE cycle.
   task automatic run_seq(input logic [19:0] sd, input logic [1:0] lv, input dig_t d,
                          input int abort_c, input int rst_c, input bit spam,
                          input bit done_start);
      int L, per, total, n_done, idx, off;
      logic [31:0] exp_v;
      L     = 8 >> lv;
      per   = L + 2;
      total = 6 * per;
      seed  = sd;
      level = lv;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= total + 1; c++) begin
         idx = (c - 1) / per;
         off = (c - 1) % per;
         if (c <= total)
            exp_v = {23'd0, (off < L), d[idx], 3'(idx), 1'b1, 1'b0};
         else
            exp_v = {23'd0, 1'b0, d[5], 3'd5, 1'b1, 1'b1};
         chk($sformatf("c%0d", c), outv(), exp_v);
         if (c == abort_c) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            chk("abort_idle", {29'd0, pos_valid, busy, done}, 32'd0);
            n_done = 0;
            for (int k = 0; k < 70; k++) begin
               @(posedge clk); #1;
               if (done) n_done++;
            end
            chk("abort_no_done", n_done, 0);
            return;
         end
         if (c == rst_c) begin
            #2 rst_n = 1'b0;
            #1 chk("rst_async", outv(), 32'd0);
            @(posedge clk); #1;
            chk("rst_hold", outv(), 32'd0);
            rst_n = 1'b1;
            return;
         end
         if (spam) begin
            start = (c % 5 == 2);
            seed  = 20'h12345;
            level = 2'd3;
         end
         if (done_start && c == total + 1) begin
            start = 1'b1;
            seed  = 20'h00000;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      chk("idle_after", {29'd0, pos_valid, busy, done}, 32'd0);
   endtask

   dig_t d_fac;
   dig_t d_zero;

   initial begin
      d_fac = '{3'd7, 3'd0, 3'd1, 3'd6, 3'd2, 3'd7};
`ifdef PATTERN_DUP_AVOID_EN
      d_zero = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1};
`else
      d_zero = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`endif
      rst_n = 1'b0;
      start = 1'b0;
      seed  = '0;
      level = '0;
      abort = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("reset_state", outv(), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_release", outv(), 32'd0);

      // level 0, extra starts during playback and one in the DONE cycle
      run_seq(20'hFAC47, 2'd0, d_fac, 0, 0, 1'b1, 1'b1);
      // start in the IDLE cycle right after DONE is accepted; level 3
      run_seq(20'hFAC47, 2'd3, d_fac, 0, 0, 1'b0, 1'b0);
      // all-zero seed
      run_seq(20'h00000, 2'd1, d_zero, 0, 0, 1'b0, 1'b0);
      // abort in SHOW of step 3 (level 0: period 3*10+3)
      run_seq(20'hFAC47, 2'd0, d_fac, 33, 0, 1'b0, 1'b0);

      // abort and start together in IDLE: start dropped
      abort = 1'b1;
      start = 1'b1;
      seed  = 20'hFAC47;
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      chk("abort_beats_start", {29'd0, pos_valid, busy, done}, 32'd0);
      @(posedge clk); #1;
      chk("still_idle", {29'd0, pos_valid, busy, done}, 32'd0);

      // reset during GAP of step 2 (level 2: period 2*4+3)
      run_seq(20'hFAC47, 2'd2, d_fac, 0, 11, 1'b0, 1'b0);
      chk("post_rst_state", outv(), 32'd0);
      // full playback from digit 0 after reset
      run_seq(20'hFAC47, 2'd0, d_fac, 0, 0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
